// File: rtl/comptador_descendent_8_bits.sv
// Loadable down-counter / countdown timer with one-cycle terminal pulse.
// Define AUTO_RELOAD_EN to make DONE reload the last start value (periodic timer).
module comptador_descendent_8_bits #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_s;
   logic [WIDTH-1:0] reload_r;
   logic [WIDTH-1:0] reload_s;
   logic             done_r;
   logic             busy_r;

   // Next-state and next-count selection; load always wins over en.
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      reload_s = reload_r;
      case (state_r)
         IDLE: begin
            if (load) begin
               count_s  = load_val;
               reload_s = load_val;
               state_s  = (load_val != CNT_ZERO) ? RUN : DONE;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (load) begin
               count_s  = load_val;
               reload_s = load_val;
               state_s  = (load_val != CNT_ZERO) ? RUN : DONE;
            end else if (en) begin
               // Terminate on 1 so the decrement can never wrap below zero.
               if (count_r > CNT_ONE) begin
                  count_s = count_r - CNT_ONE;
               end else begin
                  count_s = CNT_ZERO;
                  state_s = DONE;
               end
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (load) begin
               count_s  = load_val;
               reload_s = load_val;
               state_s  = (load_val != CNT_ZERO) ? RUN : DONE;
            end else begin
`ifdef AUTO_RELOAD_EN
               if (reload_r != CNT_ZERO) begin
                  count_s = reload_r;
                  state_s = RUN;
               end else begin
                  count_s = CNT_ZERO;
                  state_s = IDLE;
               end
`else
               count_s = CNT_ZERO;
               state_s = IDLE;
`endif
            end
         end
         default: begin
            count_s = CNT_ZERO;
            state_s = IDLE;
         end
      endcase
   end

   // State, count and decoded status registers; rst aborts without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         count_r  <= CNT_ZERO;
         reload_r <= CNT_ZERO;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         reload_r <= reload_s;
         done_r   <= (state_s == DONE);
         busy_r   <= (state_s == RUN);
      end
   end

   assign out  = count_r;
   assign zero = (count_r == CNT_ZERO);
   assign done = done_r;
   assign busy = busy_r;

endmodule
